// File: rtl/quad_phase_decoder.sv
// Quadrature decoder: synchronizes phase A/B, counts legal steps up/down,
// flags illegal double-bit jumps and tracks steady same-direction rotation.
module quad_phase_decoder #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ph_a,
    input  logic             ph_b,
    input  logic             clr,
    output logic [CNT_W-1:0] position,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             lock,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {UNLOCKED, TRACK, LOCKED} lock_state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

    logic [1:0]       sync_a_q, sync_b_q;
    logic [1:0]       s;
    logic [1:0]       p_q, p_d;
    logic [1:0]       warm_q, warm_d;
    logic [CNT_W-1:0] position_q, position_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    lock_state_t      state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic             is_fwd, is_rev, is_ill, evaluate;

    assign s = {sync_a_q[1], sync_b_q[1]};

    // Forward order 00->10->11->01 is a rotation: next = {~p[0], p[1]}.
    assign is_fwd   = (s == {~p_q[0], p_q[1]});
    assign is_rev   = (s == {p_q[0], ~p_q[1]});
    assign is_ill   = (s == ~p_q);
    // The synchronizers come out of reset holding 00, so p keeps reloading
    // until real pin levels have propagated; otherwise pins at 11 would
    // look like a jump right after release.
    assign evaluate = (warm_q == 2'd0);

    always_comb begin
        p_d        = s;
        warm_d     = evaluate ? 2'd0 : warm_q - 2'd1;
        position_d = position_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        state_d    = state_q;
        run_d      = run_q;

        if (evaluate) begin
            if (is_fwd || is_rev) begin
                step_d     = 1'b1;
                dir_d      = is_fwd;
                position_d = is_fwd ? position_q + CNT_W'(1) : position_q - CNT_W'(1);
                case (state_q)
                    UNLOCKED: begin
                        state_d = TRACK;
                        run_d   = 4'd1;
                    end
                    TRACK: begin
                        if (is_fwd == dir_q) begin
                            run_d = run_q + 4'd1;
                            if (run_q + 4'd1 == LOCK_RUN) state_d = LOCKED;
                        end else begin
                            run_d = 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (is_fwd != dir_q) begin
                            state_d = TRACK;
                            run_d   = 4'd1;
                        end
                    end
                    default: begin
                        state_d = UNLOCKED;
                        run_d   = 4'd0;
                    end
                endcase
            end else if (is_ill) begin
                err_d     = 1'b1;
                err_cnt_d = (err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
                state_d   = UNLOCKED;
                run_d     = 4'd0;
            end
        end

        if (clr) begin
            position_d = '0;
            err_cnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a_q   <= 2'b00;
            sync_b_q   <= 2'b00;
            p_q        <= 2'b00;
            warm_q     <= 2'd3;
            position_q <= '0;
            dir_q      <= 1'b1;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
            state_q    <= UNLOCKED;
            run_q      <= 4'd0;
        end else begin
            sync_a_q   <= {sync_a_q[0], ph_a};
            sync_b_q   <= {sync_b_q[0], ph_b};
            p_q        <= p_d;
            warm_q     <= warm_d;
            position_q <= position_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            state_q    <= state_d;
            run_q      <= run_d;
        end
    end

    assign position = position_q;
    assign dir      = dir_q;
    assign step     = step_q;
    assign err      = err_q;
    assign lock     = (state_q == LOCKED);
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_quad_phase_decoder.sv
// Scoreboarded random bench for quad_phase_decoder; the reference model works
// on phase indices around the quadrature cycle and run lengths.
module tb_quad_phase_decoder;

    localparam int CW = 4;
    localparam int LK = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ph_a = 1'b1, ph_b = 1'b1, clr = 1'b0;
    logic [CW-1:0] position;
    logic          dir, step, err, lock;
    logic [7:0]    err_cnt;

    quad_phase_decoder #(.CNT_W(CW), .LOCK_CNT(LK)) dut (
        .clk(clk), .rst(rst), .ph_a(ph_a), .ph_b(ph_b), .clr(clr),
        .position(position), .dir(dir), .step(step), .err(err),
        .lock(lock), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int pos;
        bit dir;
        bit lock;
        int errc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0, bad = 0, npulse = 0;

    // reference model state
    int m_idx, m_pos, m_run, m_errc;
    bit m_dir;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int idx_of(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] pins_of(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_reset(input logic [1:0] pins);
        m_idx = idx_of(pins); m_pos = 0; m_run = 0; m_errc = 0; m_dir = 1'b1;
    endtask

    // Called just after a rising edge; occupies four clock cycles.
    task automatic apply(input logic [1:0] np, input bit clr_ev);
        int   d;
        bit   fwd, ev, is_e;
        exp_t e;
        d  = (idx_of(np) - m_idx + 4) % 4;
        ev = 1'b0; is_e = 1'b0;
        if (d == 1 || d == 3) begin
            fwd = (d == 1);
            if (m_run == 0 || fwd != m_dir) m_run = 1;
            else if (m_run < LK) m_run++;
            m_dir = fwd;
            m_pos = (m_pos + (fwd ? 1 : (1 << CW) - 1)) % (1 << CW);
            ev = 1'b1;
        end else if (d == 2) begin
            m_run  = 0;
            m_errc = (m_errc < 255) ? m_errc + 1 : 255;
            ev = 1'b1; is_e = 1'b1;
        end
        if (clr_ev) begin
            m_pos = 0; m_errc = 0;
        end
        m_idx = idx_of(np);
        if (ev) begin
            e.is_err = is_e; e.pos = m_pos; e.dir = m_dir;
            e.lock = (m_run >= LK); e.errc = m_errc;
            q.push_back(e);
        end
        ph_a = np[1]; ph_b = np[0];
        @(posedge clk); @(posedge clk); #1;
        if (clr_ev) clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        m_pos = 0; m_errc = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && (step || err)) begin
            npulse++;
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_pulse step=%0b err=%0b exp=none at %0t", step, err, $time);
            end else begin
                mon_e = q.pop_front();
                chk("pulse_err", int'(err), int'(mon_e.is_err));
                chk("pulse_step", int'(step), int'(!mon_e.is_err));
                chk("position", int'(position), mon_e.pos);
                chk("dir", int'(dir), int'(mon_e.dir));
                chk("lock", int'(lock), int'(mon_e.lock));
                chk("err_cnt", int'(err_cnt), mon_e.errc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int saved;
        // reset with pins at 11, then hold
        repeat (3) @(posedge clk);
        #1;
        chk("rst_position", int'(position), 0);
        chk("rst_dir", int'(dir), 1);
        chk("rst_lock", int'(lock), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_pulses", int'(step) + int'(err), 0);
        rst = 1'b0;
        model_reset(2'b11);
        repeat (8) @(posedge clk);
        #1;
        chk("hold11_position", int'(position), 0);
        chk("hold11_pulses", npulse, 0);

        // eight forward steps, lock on the fourth
        for (int i = 0; i < 8; i++) apply(pins_of(m_idx + 1), 1'b0);
        chk("fwd8_position", int'(position), 8);
        chk("fwd8_lock", int'(lock), 1);

        // one reverse step out of lock
        apply(pins_of(m_idx + 3), 1'b0);
        chk("rev_lock", int'(lock), 0);
        chk("rev_dir", int'(dir), 0);

        // illegal jump
        apply(pins_of(m_idx + 2), 1'b0);
        chk("ill_err_cnt", int'(err_cnt), 1);
        chk("ill_position", int'(position), 7);

        // wrap both ways
        do_clr();
        apply(pins_of(m_idx + 3), 1'b0);
        chk("wrap_down", int'(position), 15);
        apply(pins_of(m_idx + 1), 1'b0);
        chk("wrap_up", int'(position), 0);

        // clr coinciding with an evaluated step
        for (int i = 0; i < 3; i++) apply(pins_of(m_idx + 1), 1'b0);
        apply(pins_of(m_idx + 1), 1'b1);
        chk("clr_step_position", int'(position), 0);
        chk("clr_step_dir", int'(dir), 1);

        // random moves
        for (int i = 0; i < 200; i++)
            apply(pins_of($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));

        // reset mid-transition, asserted between edges
        saved = npulse;
        ph_a = ~ph_a;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_position", int'(position), 0);
        chk("async_rst_dir", int'(dir), 1);
        chk("async_rst_lock", int'(lock), 0);
        chk("async_rst_err_cnt", int'(err_cnt), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset({ph_a, ph_b});
        repeat (6) @(posedge clk);
        #1;
        chk("midrot_no_pulse", npulse, saved);
        chk("midrot_position", int'(position), 0);

        // saturation of the illegal-transition counter
        for (int i = 0; i < 300; i++) apply(pins_of(m_idx + 2), 1'b0);
        chk("sat_err_cnt", int'(err_cnt), 255);
        chk("sat_lock", int'(lock), 0);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quad_phase_decoder.md
QUAD_PHASE_DECODER -- requirements
Module: quad_phase_decoder

Interface
REQ-001 Parameter CNT_W, default 16, position counter width.
REQ-002 Parameter LOCK_CNT, default 4, consecutive same-direction steps needed for lock (legal range 2..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ph_a  input  1  quadrature phase A, asynchronous to clk.
REQ-006 ph_b  input  1  quadrature phase B, asynchronous to clk.
REQ-007 clr  input  1  synchronous clear of position and err_cnt.
REQ-008 position  output  CNT_W  signed-agnostic up/down step count.
REQ-009 dir  output  1  1 = forward (A leads B), 0 = reverse.
REQ-010 step  output  1  one-cycle pulse per legal transition.
REQ-011 err  output  1  one-cycle pulse per illegal transition.
REQ-012 lock  output  1  level; steady same-direction rotation detected.
REQ-013 err_cnt  output  8  saturating illegal-transition count.

Function
REQ-014 Each of ph_a and ph_b SHALL pass through a 2-flop synchronizer; decode uses only the synchronized pair s = {a_s,b_s}.
REQ-015 Previous-state register p SHALL hold the last evaluated s; every clk, s is compared with p, then p <= s.
REQ-016 Forward sequence SHALL be 00->10->11->01->00; the reverse of each pair is a reverse step.
REQ-017 s == p: no step, no err, outputs hold.
REQ-018 Legal step (one bit changed): step=1 for one cycle, position +1 (forward) or -1 (reverse), dir set to step direction.
REQ-019 Illegal (both bits changed): err=1 for one cycle, position and dir unchanged, err_cnt +1 saturating at 255.
REQ-020 position SHALL wrap modulo 2^CNT_W in both directions (max+1 -> 0, 0-1 -> all ones).
REQ-021 Latency: a pin change stable before rising edge k SHALL produce step/err and updated position/dir after edge k+2 (visible in cycle k+2..k+3), i.e. 3 edges pin-to-output.
REQ-022 First-sample rule: the first clk after reset deassertion SHALL load p from s without evaluation (no step, no err), regardless of pin levels.
REQ-023 Lock FSM states UNLOCKED, TRACK, LOCKED with a 4-bit run counter; lock=1 only in LOCKED.
REQ-024 UNLOCKED: on legal step -> TRACK, run=1.
REQ-025 TRACK: same-direction step -> run+1; when run+1 == LOCK_CNT -> LOCKED; opposite-direction step -> stay TRACK, run=1.
REQ-026 LOCKED: same-direction step -> stay; opposite-direction step -> TRACK, run=1.
REQ-027 Any illegal transition in any state -> UNLOCKED, run=0, same cycle as err.
REQ-028 clr=1: position <= 0 and err_cnt <= 0 next edge; clr has priority over a simultaneous step/err (step and err pulses still issued, dir and FSM still updated).
REQ-029 No state changes while s == p; lock is not timed out by idle inputs.

Reset
REQ-030 rst=1 SHALL immediately clear: synchronizers, p, position=0, dir=1, step=0, err=0, lock=0, err_cnt=0, FSM=UNLOCKED, run=0, first-sample flag set.
REQ-031 Reset asserted mid-rotation SHALL abandon the in-flight transition; no step/err pulse is emitted for it after release.

Verification
REQ-032 Reset with pins at 11, release, hold -> no step, no err, position=0 after 5 cycles.
REQ-033 Drive 8 forward steps (00,10,11,01,...) spaced 4 cycles, LOCK_CNT=4 -> 8 step pulses, position=8, dir=1, lock rises on 4th step pulse.
REQ-034 From LOCKED forward, one reverse step -> position decrements by 1, dir=0, lock=0 same cycle, FSM TRACK run=1.
REQ-035 Jump 00->11 -> err pulse once, position unchanged, err_cnt=1, lock=0; 300 illegal jumps -> err_cnt=255.
REQ-036 CNT_W=4, position=15, forward step -> 0; reverse step -> 15.
REQ-037 clr asserted in the same cycle step is evaluated -> position=0 next cycle, step pulse still seen, dir updated.
